// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO frame register.
//   sipo_clog2      : ceil(log2(v)), minimum 1; sizes the bit counter.
//   MSB_FIRST_ORDER : first received bit lands in the top bit of the word.
//   LSB_FIRST_ORDER : first received bit lands in bit 0 of the word.
package sipo_pkg;

    localparam int MSB_FIRST_ORDER = 1;
    localparam int LSB_FIRST_ORDER = 0;

    function automatic int sipo_clog2(input int v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sipo_frame_reg.sv
// Serial-in/parallel-out register with frame counting and a holding register.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high
//   en       : shift enable (si sampled only when en=1)
//   si       : serial data in
//   clr      : synchronous frame abort; clears shift state and overrun
//   po_ready : consumer accepts po while po_valid=1
//   shift_q  : live shift-register contents
//   bit_cnt  : bits received in the current frame, 0..WIDTH-1
//   po       : last completed frame
//   po_valid : po holds an unaccepted frame
//   overrun  : sticky, a frame completed over an unaccepted one
module sipo_frame_reg
    import sipo_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = MSB_FIRST_ORDER,
    localparam int  CNT_W     = sipo_clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             si,
    input  logic             clr,
    input  logic             po_ready,
    output logic [WIDTH-1:0] shift_q,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] next_shift;
    logic             last_bit;
    logic             complete;
    logic             accept;

    always_comb begin
        next_shift = '0;
        if (MSB_FIRST != 0) begin
            next_shift = {shift_q[WIDTH-2:0], si};
        end else begin
            next_shift = {si, shift_q[WIDTH-1:1]};
        end
    end

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign complete = en & ~clr & last_bit;
    assign accept   = po_valid & po_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (clr) begin
                shift_q <= '0;
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (en) begin
                shift_q <= next_shift;
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end

            // Holding register runs independently of clr; completion never
            // coincides with clr, so the overrun set and clear cannot collide.
            if (complete) begin
                po       <= next_shift;
                po_valid <= 1'b1;
                if (po_valid && !po_ready) overrun <= 1'b1;
            end else if (accept) begin
                po_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_reg.sv
module tb_sipo_frame_reg;
    import sipo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0, si = 1'b0, clr = 1'b0, po_ready = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: W=8 MSB-first, 1: W=8 LSB-first, 2: W=5 MSB-first.
    logic [7:0] sq0, po0, sq1, po1;
    logic [4:0] sq2, po2;
    logic [2:0] bc0, bc1, bc2;
    logic       pv0, pv1, pv2, ov0, ov1, ov2;

    sipo_frame_reg #(.WIDTH(8), .MSB_FIRST(MSB_FIRST_ORDER)) u_msb8 (
        .clk(clk), .reset(reset), .en(en), .si(si), .clr(clr), .po_ready(po_ready),
        .shift_q(sq0), .bit_cnt(bc0), .po(po0), .po_valid(pv0), .overrun(ov0));
    sipo_frame_reg #(.WIDTH(8), .MSB_FIRST(LSB_FIRST_ORDER)) u_lsb8 (
        .clk(clk), .reset(reset), .en(en), .si(si), .clr(clr), .po_ready(po_ready),
        .shift_q(sq1), .bit_cnt(bc1), .po(po1), .po_valid(pv1), .overrun(ov1));
    sipo_frame_reg #(.WIDTH(5), .MSB_FIRST(MSB_FIRST_ORDER)) u_msb5 (
        .clk(clk), .reset(reset), .en(en), .si(si), .clr(clr), .po_ready(po_ready),
        .shift_q(sq2), .bit_cnt(bc2), .po(po2), .po_valid(pv2), .overrun(ov2));

    logic [7:0] a_sq [3];
    logic [7:0] a_po [3];
    logic [2:0] a_bc [3];
    logic       a_pv [3];
    logic       a_ov [3];
    assign a_sq[0] = sq0; assign a_sq[1] = sq1; assign a_sq[2] = {3'b0, sq2};
    assign a_po[0] = po0; assign a_po[1] = po1; assign a_po[2] = {3'b0, po2};
    assign a_bc[0] = bc0; assign a_bc[1] = bc1; assign a_bc[2] = bc2;
    assign a_pv[0] = pv0; assign a_pv[1] = pv1; assign a_pv[2] = pv2;
    assign a_ov[0] = ov0; assign a_ov[1] = ov1; assign a_ov[2] = ov2;

    int tests = 0;
    int fails = 0;

    // Reference model: the stream of bits received since the last clr/reset.
    // Word value and counter are derived from that stream arithmetically.
    int         wid [3]  = '{8, 8, 5};
    bit         msbf [3] = '{1'b1, 1'b0, 1'b1};
    bit         hist [$];
    int         nbits;
    logic [7:0] m_po [3];
    logic       m_pv [3];
    logic       m_ov [3];

    function automatic logic [7:0] exp_shift(input int d);
        logic [7:0] v;
        int k;
        v = '0;
        k = (hist.size() < wid[d]) ? hist.size() : wid[d];
        for (int a = 0; a < k; a++) begin
            // a = age of the bit: 0 is the most recently received one
            if (hist[hist.size() - 1 - a]) begin
                if (msbf[d]) v = v | (8'd1 << a);
                else         v = v | (8'd1 << (wid[d] - 1 - a));
            end
        end
        return v;
    endfunction

    function automatic logic [2:0] exp_cnt(input int d);
        return 3'(nbits % wid[d]);
    endfunction

    task automatic model_reset();
        hist.delete();
        nbits = 0;
        for (int d = 0; d < 3; d++) begin
            m_po[d] = '0; m_pv[d] = 1'b0; m_ov[d] = 1'b0;
        end
    endtask

    task automatic model_update(input logic e, input logic s, input logic c, input logic r);
        int nb;
        bit comp;
        nb = nbits;
        if (e && !c) begin
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
            nbits++;
        end
        for (int d = 0; d < 3; d++) begin
            comp = e && !c && ((nb % wid[d]) == wid[d] - 1);
            if (comp) begin
                m_po[d] = exp_shift(d);
                if (m_pv[d] && !r) m_ov[d] = 1'b1;
                m_pv[d] = 1'b1;
            end else if (m_pv[d] && r) begin
                m_pv[d] = 1'b0;
            end
            if (c) m_ov[d] = 1'b0;
        end
        if (c) begin
            hist.delete();
            nbits = 0;
        end
    endtask

    // Drive one cycle; returns 1 time unit after the sampling edge.
    task automatic step(input logic e, input logic s, input logic c, input logic r);
        en = e; si = s; clr = c; po_ready = r;
        model_update(e, s, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 0; si = 0; clr = 0; po_ready = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rdy_last);
        for (int i = 7; i >= 0; i--) step(1'b1, v[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (a_sq[d] !== 8'h00 || a_bc[d] !== 3'd0 || a_po[d] !== 8'h00 ||
                a_pv[d] !== 1'b0 || a_ov[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset inst%0d: sq=%h bc=%0d po=%h pv=%b ov=%b, want all 0",
                         d, a_sq[d], a_bc[d], a_po[d], a_pv[d], a_ov[d]);
            end
        end
    endtask

    task automatic test_msb_frame();
        do_reset();
        send_byte(8'hA5, 1'b0);
        tests++;
        if (po0 !== 8'hA5 || pv0 !== 1'b1 || bc0 !== 3'd0 || ov0 !== 1'b0) begin
            fails++;
            $display("FAIL msb_frame: po=%h pv=%b bc=%0d ov=%b, want a5 1 0 0", po0, pv0, bc0, ov0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (pv0 !== 1'b0 || po0 !== 8'hA5) begin
            fails++;
            $display("FAIL msb_accept: pv=%b po=%h, want 0 a5", pv0, po0);
        end
    endtask

    task automatic test_lsb_frame();
        do_reset();
        send_byte(8'h1E, 1'b0);
        tests++;
        if (po1 !== 8'h78 || pv1 !== 1'b1) begin
            fails++;
            $display("FAIL lsb_frame: po=%h pv=%b, want 78 1", po1, pv1);
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (a_po[d] !== m_po[d] || a_sq[d] !== exp_shift(d)) begin
                fails++;
                $display("FAIL lsb_model inst%0d: po=%h sq=%h, want %h %h",
                         d, a_po[d], a_sq[d], m_po[d], exp_shift(d));
            end
        end
    endtask

    task automatic test_en_gaps();
        logic [7:0] v;
        v = 8'h3C;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, v[i], 1'b0, 1'b0);
            if (i == 6 || i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b1, 1'b0, 1'b0);
                    tests++;
                    if (bc0 !== 3'(8 - i) || pv0 !== 1'b0) begin
                        fails++;
                        $display("FAIL en_gap: bc=%0d pv=%b, want %0d 0", bc0, pv0, 8 - i);
                    end
                end
            end
            if (i > 0) begin
                tests++;
                if (pv0 !== 1'b0) begin
                    fails++;
                    $display("FAIL en_early_valid: pv=%b want 0", pv0);
                end
            end
        end
        tests++;
        if (po0 !== 8'h3C || pv0 !== 1'b1) begin
            fails++;
            $display("FAIL en_frame: po=%h pv=%b, want 3c 1", po0, pv0);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        tests++;
        if (po0 !== 8'h22 || pv0 !== 1'b1 || ov0 !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: po=%h pv=%b ov=%b, want 22 1 1", po0, pv0, ov0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (ov0 !== 1'b0 || pv0 !== 1'b1 || po0 !== 8'h22) begin
            fails++;
            $display("FAIL overrun_clr: ov=%b pv=%b po=%h, want 0 1 22", ov0, pv0, po0);
        end
        send_byte(8'h33, 1'b1);
        tests++;
        if (po0 !== 8'h33 || pv0 !== 1'b1 || ov0 !== 1'b0) begin
            fails++;
            $display("FAIL accept_complete: po=%h pv=%b ov=%b, want 33 1 0", po0, pv0, ov0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        tests++;
        if (sq0 !== 8'h00 || bc0 !== 3'd0) begin
            fails++;
            $display("FAIL clr_abort: sq=%h bc=%0d, want 00 0", sq0, bc0);
        end
        send_byte(8'h5A, 1'b0);
        tests++;
        if (po0 !== 8'h5A || pv0 !== 1'b1) begin
            fails++;
            $display("FAIL clr_frame: po=%h pv=%b, want 5a 1", po0, pv0);
        end
        // Asynchronous reset between edges, mid-frame.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (a_sq[d] !== 8'h00 || a_bc[d] !== 3'd0 || a_po[d] !== 8'h00 ||
                a_pv[d] !== 1'b0 || a_ov[d] !== 1'b0) begin
                fails++;
                $display("FAIL async_reset inst%0d: sq=%h bc=%0d po=%h pv=%b ov=%b, want all 0",
                         d, a_sq[d], a_bc[d], a_po[d], a_pv[d], a_ov[d]);
            end
        end
        do_reset();
        v = 8'($urandom);
        send_byte(v, 1'b0);
        tests++;
        if (po0 !== v || pv0 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_frame: po=%h pv=%b, want %h 1", po0, pv0, v);
        end
    endtask

    task automatic test_width5();
        logic [2:0] want_bc [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        bit         bits [5]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        tests++;
        if (bc2 !== 3'd0) begin
            fails++;
            $display("FAIL w5_cnt_start: bc=%0d want 0", bc2);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            tests++;
            if (bc2 !== want_bc[i]) begin
                fails++;
                $display("FAIL w5_cnt step%0d: bc=%0d want %0d", i, bc2, want_bc[i]);
            end
        end
        tests++;
        if (po2 !== 5'h16 || pv2 !== 1'b1) begin
            fails++;
            $display("FAIL w5_frame: po=%h pv=%b, want 16 1", po2, pv2);
        end
    endtask

    task automatic test_random();
        logic e, s, c, r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 3) != 0);
            s = 1'($urandom);
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 2) == 0);
            step(e, s, c, r);
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (a_sq[d] !== exp_shift(d) || a_bc[d] !== exp_cnt(d) || a_po[d] !== m_po[d] ||
                    a_pv[d] !== m_pv[d] || a_ov[d] !== m_ov[d]) begin
                    fails++;
                    $display("FAIL random cyc%0d inst%0d: sq=%h bc=%0d po=%h pv=%b ov=%b, want %h %0d %h %b %b",
                             n, d, a_sq[d], a_bc[d], a_po[d], a_pv[d], a_ov[d],
                             exp_shift(d), exp_cnt(d), m_po[d], m_pv[d], m_ov[d]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_en_gaps();
        test_overrun();
        test_abort();
        test_width5();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_frame_reg.md
Name: sipo_frame_reg

Overview:
Parametrised serial-in/parallel-out register with frame counting and an output holding register. Replaces the fixed 4-bit SIPO: configurable width and bit order, shift-enable gating, and a valid/ready handshake with overrun detection on the parallel side. Sits between a serial input pin/deserialiser front end and a word-oriented consumer.

Parameters:
WIDTH, 8, frame/word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = first received bit lands in po[WIDTH-1]; 0 = first received bit lands in po[0].
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  shift enable; si is sampled only when en=1.
si  input  1  serial data in.
clr  input  1  synchronous frame abort: clears shift state and overrun.
po_ready  input  1  consumer accepts po when po_valid=1.
shift_q  output  WIDTH  live shift-register contents.
bit_cnt  output  CNT_W  bits received in the current frame, 0..WIDTH-1.
po  output  WIDTH  last completed frame (holding register).
po_valid  output  1  po holds an unaccepted frame.
overrun  output  1  sticky: a frame completed while the previous one was unaccepted.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset is asynchronous and active-high, on port reset. While reset=1, shift_q, bit_cnt, po, po_valid and overrun are all 0.
- Shift when en=1 and clr=0:
  - MSB_FIRST=1: shift_q <= {shift_q[WIDTH-2:0], si}.
  - MSB_FIRST=0: shift_q <= {si, shift_q[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- en=0 and clr=0: shift_q and bit_cnt hold. Gaps of any length mid-frame are legal.
- Frame completion: en=1, clr=0 and bit_cnt==WIDTH-1.
  - bit_cnt wraps to 0.
  - po <= the post-shift value (the new shift_q), in the same edge.
  - po_valid <= 1.
  - Latency: po/po_valid are visible immediately after the edge that samples the WIDTH-th bit.
  - shift_q is not cleared; the next frame shifts over it.
- Handshake:
  - Accept occurs when po_valid=1 and po_ready=1 on an edge.
  - Accept without completion: po_valid <= 0, po holds its value.
  - Accept and completion on the same edge: po_valid stays 1, po takes the new frame, no overrun.
  - po_ready is ignored while po_valid=0.
- Overrun:
  - Completion while po_valid=1 and po_ready=0: po is overwritten with the new frame, po_valid stays 1, overrun <= 1.
  - overrun is cleared only by clr or reset.
- clr (priority over en):
  - shift_q <= 0, bit_cnt <= 0, overrun <= 0.
  - po and po_valid are unaffected, and the handshake continues normally in the same cycle.
  - si is not sampled on a clr cycle.
- Reset mid-frame: partial frame discarded; the first bit after reset deasserts is bit 0 of a new frame.
- bit_cnt never reaches WIDTH. For non-power-of-2 WIDTH, counter values above WIDTH-1 are unreachable and need no handling.

Decomposition:
- Shared package sipo_pkg: a clog2-style width function for CNT_W, and localparams MSB_FIRST_ORDER=1 and LSB_FIRST_ORDER=0 for instantiating code.
- Single module; no sub-module. The counter and holding register are too small to justify a split.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: reset for 2 cycles, then shift the bits of 0xA5 (1,0,1,0,0,1,0,1) with en=1 and po_ready=0 -> after the 8th edge po=0xA5, po_valid=1, bit_cnt=0, overrun=0. Raise po_ready for 1 cycle -> po_valid=0, po still 0xA5.
2. MSB_FIRST=0: shift 0,0,0,1,1,1,1,0 (0x1E sent MSB first) -> po=0x78, po_valid=1.
3. en gaps: shift 0x3C with en low for 3 cycles after bits 2 and 5 -> bit_cnt holds during each gap, po=0x3C only after the 8th enabled bit, no early po_valid.
4. Overrun: complete 0x11 and leave it unaccepted, then complete 0x22 with po_ready=0 -> po=0x22, po_valid=1, overrun=1. Pulse clr -> overrun=0, po_valid=1. Repeat with po_ready=1 on the completing edge of 0x33 -> po=0x33, po_valid=1, overrun=0.
5. Abort:
   - Shift 5 bits, pulse clr -> shift_q=0, bit_cnt=0. Then 8 bits of 0x5A -> po=0x5A.
   - Assert reset asynchronously mid-frame (between edges) -> all outputs 0 immediately, without waiting for a clk edge.
6. WIDTH=5 (non-power-of-2): shift 1,0,1,1,0 -> po=0x16, bit_cnt sequence 0,1,2,3,4,0, never 5–7.
